fir_tap_sequencer: RTL
======================

# fir_tap_sequencer

Upstream control and coefficient source for the transposed FIR datapath. It latches each 3-bit input sample on the 300 kHz sample enable. It then steps through four cascaded multiply/add/shift stages, one stage per 12 MHz cycle, and presents that stage's three coefficients together with a one-cycle accumulate enable. It also owns the 12-entry coefficient bank, which software writes through a valid/ready port that stays safe while a sequence is running.

## Interface
Parameters:
- NUM_STAGES, 4, number of cascaded 3-tap stages driven (taps = 3*NUM_STAGES = 12)
- COEFF_W, 16, coefficient width (signed)

Ports:
- iClk_12M  in  1  system clock
- iRsn  in  1  reset; one clock, asynchronous active-low reset
- iEnSample_300k  in  1  one-cycle sample strobe
- iFirIn  in  3  signed input sample, sampled on strobe
- iCoeffWrValid  in  1  coefficient write request
- iCoeffWrAddr  in  4  tap index 0..11
- iCoeffWrData  in  16  signed coefficient
- oCoeffWrReady  out  1  write can be accepted this cycle
- oFirIn  out  3  latched sample held for the whole sequence
- oCoeff1/oCoeff2/oCoeff3  out  16 each  coefficients of the current stage
- oEnAcc  out  1  accumulate enable for selected stage
- oStageSel  out  2  stage index 0..NUM_STAGES-1
- oBusy  out  1  sequence in progress
- oDone  out  1  one-cycle pulse after the last stage
- oOverrun  out  1  sticky: strobe arrived while busy
- oAddrErr  out  1  one-cycle pulse: write address >= 12

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: iEnSample_300k=1 -> latch iFirIn into oFirIn, clear stage counter, go RUN.
- RUN: oEnAcc=1 and oBusy=1 every cycle. oStageSel = counter.
  - oCoeff1/2/3 = bank[3*s], bank[3*s+1], bank[3*s+2].
  - Counter increments each cycle. After stage NUM_STAGES-1, go DONE.
- DONE: oDone=1 for one cycle, then IDLE.
- Strobe in RUN or DONE: ignored, oOverrun set. It clears only on reset.
- Coefficient bank: 12 x 16-bit registers. A write is accepted when iCoeffWrValid && oCoeffWrReady.
  - If in IDLE with no strobe this cycle, the write commits to the bank directly.
  - Otherwise it is stored in a single pending slot.
  - The pending slot commits on the first IDLE cycle with no strobe.
- oCoeffWrReady = pending slot empty. This guarantees the bank never changes mid-sequence.
- Address >= 12: write is accepted (handshake completes), data discarded, oAddrErr pulses the cycle after acceptance. The address is checked at acceptance.
- Sample and coefficient outputs are pass-through registers; no arithmetic. Signedness is preserved bit-exact.

## Timing
- Reset values (async assert, sync to clock on release):
  - All outputs 0. Bank all 0. Pending slot empty. FSM IDLE.
  - oCoeffWrReady = 1 from the first cycle after reset release.
- Strobe sampled at edge T (IDLE):
  - oFirIn valid from T+1.
  - oEnAcc high T+1..T+NUM_STAGES with oStageSel 0,1,2,3.
  - oDone high at T+NUM_STAGES+1.
  - IDLE again at T+NUM_STAGES+2.
- oCoeff1..3 change in the same cycle as oStageSel. Outside RUN they show stage 0 coefficients.
- oFirIn holds until the next accepted strobe.
- Sequence length (6 cycles) is far below the 40-cycle sample period. Overrun indicates a strobe source error.
- A direct write takes effect on bank reads from the next cycle. A pending write takes effect one cycle after its commit cycle.
- Reset asserted mid-RUN: outputs drop to 0 immediately, the sequence is abandoned, and the pending write is lost.

## Test plan
- Reset, write bank[k]=100*k+1 for k=0..11, strobe with iFirIn=-3:
  - oFirIn=-3.
  - Stage 0 coeffs 1/101/201 through stage 3 coeffs 901/1001/1101 on cycles T+1..T+4.
  - oDone at T+5.
- Write addr 5 = 0x7FFF at T+2 during RUN:
  - Accepted into pending, oCoeffWrReady=0 until commit.
  - Current sequence still shows old bank[5].
  - Next sequence shows 0x7FFF.
- Second write during RUN while pending is full: Valid held with Ready=0; accepted after the first commits; both land in the bank.
- Strobe at T+3 of a running sequence: ignored, sequence timing unchanged, oOverrun=1 and stays 1.
- Write addr 12 data 0x1234: oAddrErr one-cycle pulse, bank unchanged.
- Assert iRsn low at T+2 of RUN:
  - All outputs 0 asynchronously.
  - After release, FSM is IDLE, bank is 0, and the next strobe runs a normal 4-stage sequence.

Source files
------------

// File: rtl/fir_tap_sequencer.sv
// Sample latch, stage sequencer and coefficient bank feeding a cascaded 3-tap FIR datapath.
// Bank writes that arrive while a sequence is in flight are parked in one pending slot.
module fir_tap_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int COEFF_W    = 16
) (
    input  logic                      iClk_12M,
    input  logic                      iRsn,
    input  logic                      iEnSample_300k,
    input  logic signed [2:0]         iFirIn,
    input  logic                      iCoeffWrValid,
    input  logic [3:0]                iCoeffWrAddr,
    input  logic signed [COEFF_W-1:0] iCoeffWrData,
    output logic                      oCoeffWrReady,
    output logic signed [2:0]         oFirIn,
    output logic signed [COEFF_W-1:0] oCoeff1,
    output logic signed [COEFF_W-1:0] oCoeff2,
    output logic signed [COEFF_W-1:0] oCoeff3,
    output logic                      oEnAcc,
    output logic [1:0]                oStageSel,
    output logic                      oBusy,
    output logic                      oDone,
    output logic                      oOverrun,
    output logic                      oAddrErr
);

    localparam int TAPS = 3 * NUM_STAGES;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e                     state_q, state_d;
    logic [1:0]                 stage_q, stage_d;
    logic signed [2:0]          fir_in_q, fir_in_d;
    logic                       en_acc_q, en_acc_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       overrun_q, overrun_d;
    logic                       addr_err_q, addr_err_d;
    logic                       ready_q, ready_d;
    logic                       pend_valid_q, pend_valid_d;
    logic [3:0]                 pend_addr_q, pend_addr_d;
    logic signed [COEFF_W-1:0]  pend_data_q, pend_data_d;
    logic signed [COEFF_W-1:0]  bank_q [TAPS];
    logic signed [COEFF_W-1:0]  bank_d [TAPS];

    logic       wr_accept;
    logic       addr_ok;
    logic       bank_open;
    logic [3:0] coeff_base;

    assign wr_accept = iCoeffWrValid && ready_q;
    assign addr_ok   = (iCoeffWrAddr < 4'(TAPS));
    // The bank may only change while no sequence is running or about to start.
    assign bank_open = (state_q == IDLE) && !iEnSample_300k;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        stage_d      = stage_q;
        fir_in_d     = fir_in_q;
        en_acc_d     = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        overrun_d    = overrun_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        bank_d       = bank_q;

        unique case (state_q)
            IDLE: begin
                if (iEnSample_300k) begin
                    fir_in_d = iFirIn;
                    stage_d  = 2'd0;
                    en_acc_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (stage_q == 2'(NUM_STAGES - 1)) begin
                    stage_d = 2'd0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    stage_d  = stage_q + 2'd1;
                    en_acc_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                stage_d = 2'd0;
                state_d = IDLE;
            end
        endcase

        if (iEnSample_300k && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        // Pending slot full implies ready low, so a commit never races a new accept.
        if (bank_open) begin
            if (pend_valid_q) begin
                bank_d[pend_addr_q] = pend_data_q;
                pend_valid_d        = 1'b0;
            end else if (wr_accept && addr_ok) begin
                bank_d[iCoeffWrAddr] = iCoeffWrData;
            end
        end else if (wr_accept && addr_ok) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = iCoeffWrAddr;
            pend_data_d  = iCoeffWrData;
        end

        addr_err_d = wr_accept && !addr_ok;
        ready_d    = !pend_valid_d;
    end

    // Coefficients follow the stage counter, which rests at 0 outside RUN.
    always_comb begin
        coeff_base = {2'b00, stage_q} + {1'b0, stage_q, 1'b0};
        oCoeff1    = bank_q[coeff_base];
        oCoeff2    = bank_q[coeff_base + 4'd1];
        oCoeff3    = bank_q[coeff_base + 4'd2];
    end

    // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q      <= IDLE;
            stage_q      <= 2'd0;
            fir_in_q     <= '0;
            en_acc_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            addr_err_q   <= 1'b0;
            ready_q      <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            // NOTE: the bank is a small register file whose zero state is visible, so it is reset.
            for (int i = 0; i < TAPS; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            fir_in_q     <= fir_in_d;
            en_acc_q     <= en_acc_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
            addr_err_q   <= addr_err_d;
            ready_q      <= ready_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            for (int i = 0; i < TAPS; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    assign oCoeffWrReady = ready_q;
    assign oFirIn        = fir_in_q;
    assign oEnAcc        = en_acc_q;
    assign oStageSel     = stage_q;
    assign oBusy         = busy_q;
    assign oDone         = done_q;
    assign oOverrun      = overrun_q;
    assign oAddrErr      = addr_err_q;

endmodule
